// File: rtl/mem_lsu_master_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, exception codes,
// FSM encodings and the alignment rule used at accept time.
package mem_lsu_master_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsu_op_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_RSP  = 3'd3,
        ST_EXC  = 3'd4
    } lsu_state_e;

    function automatic logic is_store(input lsu_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic misaligned(input lsu_op_e op, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:         bad = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = lo[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_master_lane_ext.sv
// Byte/half lane handling: merges sub-word store data into the read word and
// sign/zero-extends the selected lane for loads (little-endian lanes).
import mem_lsu_master_pkg::*;

module lsu_lane_ext (
    input  lsu_op_e     i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_ext
);

    logic signed [15:0] w_half;
    logic signed [7:0]  w_byte;

    always_comb begin
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    always_comb begin
        o_merged = i_word;
        case (i_op)
            OP_SW: o_merged = i_wdata;
            OP_SH: begin
                if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
                else              o_merged[15:0]  = i_wdata[15:0];
            end
            OP_SB: begin
                case (i_addr_lo)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            default: o_merged = i_word;
        endcase
    end

    always_comb begin
        o_ext = 32'd0;
        case (i_op)
            OP_LW:   o_ext = i_word;
            OP_LH:   o_ext = 32'(w_half);
            OP_LHU:  o_ext = {16'd0, w_half};
            OP_LB:   o_ext = 32'(w_byte);
            OP_LBU:  o_ext = {24'd0, w_byte};
            default: o_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_lsu_master.sv
// MEM-stage load/store initiator for a word-only RAM: one op per handshake,
// alignment/range check, read-modify-write for SH/SB, AdEL/AdES reporting.
import mem_lsu_master_pkg::*;

module mem_lsu_master #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    lsu_state_e r_state, w_next;
    lsu_op_e    r_op;
    logic [31:0] r_addr, r_wdata, r_pc, r_word;

    lsu_op_e     w_req_op;
    logic        w_fault;
    logic [31:0] w_merged, w_ext;

    assign w_req_op = lsu_op_e'(req_op);
    assign w_fault  = misaligned(w_req_op, req_addr[1:0]) ||
                      ({1'b0, req_addr} >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LW;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_pc    <= 32'd0;
            r_word  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_op    <= w_req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_pc    <= req_pc;
            end
            if (r_state == ST_RD) r_word <= ram_rdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_fault)               w_next = ST_EXC;
                    else if (w_req_op == OP_SW) w_next = ST_WR;
                    else                       w_next = ST_RD;
                end
            end
            ST_RD:   w_next = is_store(r_op) ? ST_WR : ST_RSP;
            ST_WR:   w_next = ST_RSP;
            ST_RSP:  w_next = ST_IDLE;
            ST_EXC:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    lsu_lane_ext u_lane (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_word    (r_word),
        .i_wdata   (r_wdata),
        .o_merged  (w_merged),
        .o_ext     (w_ext)
    );

    // Pulses and the write strobe are masked by reset so a reset cycle never commits anything.
    assign req_ready = (r_state == ST_IDLE);
    assign ram_addr  = r_addr;
    assign ram_we    = (r_state == ST_WR) && !reset;
    assign ram_wdata = (r_state == ST_WR) ? w_merged : 32'd0;
    assign rsp_valid = (r_state == ST_RSP) && !reset;
    assign rsp_rdata = (rsp_valid && !is_store(r_op)) ? w_ext : 32'd0;
    assign exc_valid = (r_state == ST_EXC) && !reset;
    assign exc_code  = !exc_valid ? 5'd0 : (is_store(r_op) ? EXC_ADES : EXC_ADEL);
    assign exc_pc    = r_pc;

endmodule
